flash_xip_ctrl: RTL
===================

FLASH_XIP_CTRL -- requirements
Module: flash_xip_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 1, sck half-period in clock cycles; legal range 1..255.
REQ-002 clock  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  read request present.
REQ-005 req_ready  output  1  controller can accept a request.
REQ-006 req_addr  input  24  flash byte address.
REQ-007 rsp_valid  output  1  rsp_data holds a completed read word.
REQ-008 rsp_ready  input  1  consumer accepts rsp_data.
REQ-009 rsp_data  output  32  read word, little-endian byte order.
REQ-010 sck  output  1  SPI serial clock, idles low (mode 0).
REQ-011 ss  output  1  SPI slave select, active-low.
REQ-012 mosi  output  1  SPI master-out data.
REQ-013 miso  input  1  SPI master-in data.

Function
REQ-014 The FSM SHALL have states IDLE, SHIFT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-015 A request SHALL be accepted on the clock edge where req_valid && req_ready; IDLE -> SHIFT.
REQ-016 On acceptance the 64-bit shift frame SHALL load {8'h03, req_addr[23:2], 2'b00, 32'h0}; req_addr[1:0] ignored (word-aligned).
REQ-017 From the cycle after acceptance, ss SHALL be 0 and mosi SHALL be frame bit 63 (command MSB).
REQ-018 In SHIFT, sck SHALL run exactly 64 periods, each a low phase of CLK_DIV cycles then a high phase of CLK_DIV cycles.
REQ-019 mosi SHALL change only on the clock edge where sck goes 1->0, advancing to the next frame bit, MSB first; mosi SHALL be 0 during data bits 33..64.
REQ-020 miso SHALL be sampled on the clock edge where sck goes 0->1 (pre-edge value); only samples of periods 33..64 SHALL be kept.
REQ-021 Received data SHALL assemble bytewise: k-th received byte (k=0..3) -> rsp_data[8k+7:8k], first received bit of each byte -> bit 8k+7.
REQ-022 After the 64th high phase, sck SHALL return to 0, ss to 1 and rsp_valid to 1 in the same cycle; SHIFT -> RESP.
REQ-023 Latency acceptance->rsp_valid SHALL be 128*CLK_DIV+1 cycles (129 for CLK_DIV=1).
REQ-024 rsp_valid and rsp_data SHALL hold stable until rsp_valid && rsp_ready; then RESP -> IDLE, rsp_valid 0.
REQ-025 ss SHALL remain 1 for at least one full clock cycle between consecutive frames; sck SHALL never pulse while ss=1.
REQ-026 req_valid during SHIFT or RESP SHALL be ignored (not accepted, not lost; held by requester).
REQ-027 A bit counter SHALL be 7 bits wide (0..64), with no wrap within a frame.

Reset
REQ-028 On reset assertion, without waiting for clock: state IDLE, ss=1, sck=0, mosi=0, rsp_valid=0, rsp_data=0, req_ready=0 while reset high, counters 0.
REQ-029 Reset mid-frame SHALL abort the frame with ss high (flash model returns to command state); no response SHALL be produced for it.
REQ-030 req_ready SHALL become 1 in the first cycle after reset deasserts.

Structure
REQ-031 Package flash_xip_pkg SHALL hold the state enum, CMD_READ=8'h03, FRAME_BITS=64, DATA_BITS=32.
REQ-032 Sub-module spi_sck_gen SHALL generate sck and one-cycle rise/fall strobes from CLK_DIV, enabled by the FSM.

Verification
REQ-033 CLK_DIV=1, flash word at 0x000100 = 0xDEADBEEF, request 0x000100 -> rsp_data 0xDEADBEEF, rsp_valid at cycle 129 after acceptance.
REQ-034 Request 0x123456 -> mosi stream bytes 03 12 34 54 across sck rises 1..32, ss low for exactly 64 sck periods.
REQ-035 rsp_ready held 0 for 10 cycles after rsp_valid -> rsp_valid/rsp_data stable, req_ready 0, sck quiet.
REQ-036 Reset pulsed 40 cycles into a frame -> ss=1, sck=0 same cycle, no rsp_valid; next request to 0x000100 returns 0xDEADBEEF.
REQ-037 CLK_DIV=4, back-to-back requests with rsp_ready=1 -> each latency 513 cycles, ss high >=1 cycle between frames.

Source files
------------

// File: rtl/flash_xip_pkg.sv
// Shared definitions for the XIP flash read controller.
//   state_t     : controller FSM states
//   CMD_READ    : SPI flash READ opcode sent at the start of every frame
//   FRAME_BITS  : total sck periods per read frame (cmd + addr + data)
//   DATA_BITS   : bits returned by the flash per frame
//   bytes_to_le : maps the serial receive order onto a little-endian word
package flash_xip_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam int         FRAME_BITS = 64;
  localparam int         DATA_BITS  = 32;
  localparam int         BIT_CNT_W  = 7;
  localparam int         DIV_W      = 8;

  // The receive register fills MSB-first, so the first byte off the wire
  // lands in [31:24]. It belongs at the lowest byte address.
  function automatic logic [31:0] bytes_to_le(input logic [31:0] rx);
    return {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SPI serial clock generator.
//   clock, reset : system clock, async active-high reset
//   enable       : run sck; when low sck is parked at 0 and the divider reloads
//   sck          : serial clock, low phase first, each phase CLK_DIV cycles
//   sck_rise     : high in the cycle whose closing edge drives sck 0->1
//   sck_fall     : high in the cycle whose closing edge drives sck 1->0
module spi_sck_gen
  import flash_xip_pkg::*;
#(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic sck,
  output logic sck_rise,
  output logic sck_fall
);

  localparam logic [DIV_W-1:0] HALF_LOAD = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] half_cnt;
  logic             tick;

  assign tick     = enable && (half_cnt == '0);
  assign sck_rise = tick && !sck;
  assign sck_fall = tick && sck;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      half_cnt <= '0;
      sck      <= 1'b0;
    end else if (!enable) begin
      half_cnt <= HALF_LOAD;
      sck      <= 1'b0;
    end else if (tick) begin
      half_cnt <= HALF_LOAD;
      sck      <= !sck;
    end else begin
      half_cnt <= half_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/flash_xip_ctrl.sv
// Execute-in-place SPI flash read controller (mode 0, READ 0x03).
// Each accepted request issues one 64-period frame: opcode, word-aligned
// 24-bit address, then 32 data bits returned as a little-endian word.
//   clock, reset        : system clock, async active-high reset
//   req_valid/ready     : request handshake, req_addr = flash byte address
//   rsp_valid/ready     : response handshake, rsp_data = read word
//   sck, ss, mosi, miso : SPI pins, ss active-low
//
// state | meaning
// IDLE  | ss high, ready to accept a request
// SHIFT | ss low, frame shifting on sck
// RESP  | frame done, rsp_data held until consumed
module flash_xip_ctrl
  import flash_xip_pkg::*;
#(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        sck,
  output logic        ss,
  output logic        mosi,
  input  logic        miso
);

  state_t                  state, state_nxt;
  logic [FRAME_BITS-1:0]   frame;
  logic [DATA_BITS-1:0]    rx;
  logic [BIT_CNT_W-1:0]    bit_cnt;
  logic                    sck_rise, sck_fall;
  logic                    accept, last_fall, in_data;

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clock    (clock),
    .reset    (reset),
    .enable   (state == SHIFT),
    .sck      (sck),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall)
  );

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  // bit_cnt counts completed sck periods, so it reads 63 during the last one
  assign last_fall = sck_fall && (bit_cnt == BIT_CNT_W'(FRAME_BITS - 1));
  assign in_data   = bit_cnt >= BIT_CNT_W'(FRAME_BITS - DATA_BITS);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = SHIFT;
      SHIFT:   if (last_fall) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame   <= '0;
      rx      <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      frame   <= {CMD_READ, req_addr & ~24'h3, {DATA_BITS{1'b0}}};
      bit_cnt <= '0;
    end else if (state == SHIFT) begin
      if (sck_fall) begin
        frame   <= {frame[FRAME_BITS-2:0], 1'b0};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (sck_rise && in_data) rx <= {rx[DATA_BITS-2:0], miso};
    end
  end

  // The low half of the frame is zero, so mosi idles at 0 through the data phase.
  assign ss        = (state != SHIFT);
  assign mosi      = (state == SHIFT) && frame[FRAME_BITS-1];
  assign rsp_valid = (state == RESP);
  assign rsp_data  = bytes_to_le(rx);

endmodule
